// File: rtl/core_control_pkg.sv
// core_control_pkg: pipe-control state encodings shared by the controller and program counter
package core_control_pkg;
    localparam logic STATE_HALT    = 1'b0;
    localparam logic STATE_EXECUTE = 1'b1;

    localparam logic [1:0] CTRL_HALT  = 2'd0;
    localparam logic [1:0] CTRL_RUN   = 2'd1;
    localparam logic [1:0] CTRL_STEP  = 2'd2;
    localparam logic [1:0] CTRL_DRAIN = 2'd3;
endpackage

// File: rtl/retire_counter.sv
// retire_counter: wrapping retired-instruction counter; clear overrides a same-cycle increment
module retire_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb count_d = clear ? '0 : (inc ? count_q + WIDTH'(1) : count_q);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;

    assign count = count_q;
endmodule

// File: rtl/core_pipe_controller.sv
// core_pipe_controller: run/halt/single-step sequencing of the two-stage pipe plus retired-instruction count
module core_pipe_controller
    import core_control_pkg::*;
#(
    parameter bit RESET_RUN     = 1'b0,
    parameter int INSTRET_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     management_run,
    input  logic                     management_halt,
    input  logic                     management_step,
    input  logic                     management_clearInstret,
    input  logic                     fetch_busy,
    input  logic                     memory_busy,
    input  logic                     pipe1_hazard,
    input  logic                     pipe1_isEBREAK,
    input  logic                     haltOnEbreak,
    output logic                     state,
    output logic                     progressPipe,
    output logic                     stepPipe,
    output logic                     stallPipe,
    output logic                     halted,
    output logic                     instructionRetired,
    output logic [INSTRET_WIDTH-1:0] instretCount
);
    localparam logic [1:0] RESET_STATE = RESET_RUN ? CTRL_RUN : CTRL_HALT;

    logic [1:0] fsm_q, fsm_d;
    logic       busy, active, retire;

    assign busy               = fetch_busy | memory_busy;
    assign active             = (fsm_q == CTRL_RUN) || (fsm_q == CTRL_STEP);
    assign stepPipe           = active & ~busy;
    assign stallPipe          = active & pipe1_hazard;
    assign retire             = stepPipe & ~stallPipe;
    assign instructionRetired = retire;
    assign halted             = fsm_q == CTRL_HALT;
    assign progressPipe       = ~halted;
    assign state              = halted ? STATE_HALT : STATE_EXECUTE;

    // DRAIN lets outstanding memory traffic finish before reporting HALT
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            CTRL_HALT: fsm_d = management_step ? CTRL_STEP : (management_run ? CTRL_RUN : CTRL_HALT);
            CTRL_RUN:  fsm_d = (management_halt || (retire && pipe1_isEBREAK && haltOnEbreak)) ? CTRL_DRAIN : CTRL_RUN;
            CTRL_STEP: fsm_d = (management_halt || retire) ? CTRL_DRAIN : CTRL_STEP;
            default:   fsm_d = busy ? CTRL_DRAIN : CTRL_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) fsm_q <= RESET_STATE;
        else        fsm_q <= fsm_d;

    retire_counter #(.WIDTH(INSTRET_WIDTH)) u_instret (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (management_clearInstret),
        .inc   (retire),
        .count (instretCount)
    );
endmodule

// File: tb/tb_core_pipe_controller.sv
// tb_core_pipe_controller: vector table, random run against a reference model, and reset/wrap corner cases
module tb_core_pipe_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 0, halt = 0, step = 0, clr = 0, fb = 0, mb = 0, hz = 0, eb = 0, hoe = 0;
    logic state, progress, step_pipe, stall_pipe, halted, retired;
    logic [31:0] cnt;
    logic b_fb = 1'b1, b_clr = 1'b0;
    logic b_state, b_progress, b_step_pipe, b_stall_pipe, b_halted, b_retired;
    logic [3:0] b_cnt;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    core_pipe_controller dut (
        .clk(clk), .rst_n(rst_n),
        .management_run(run), .management_halt(halt), .management_step(step),
        .management_clearInstret(clr),
        .fetch_busy(fb), .memory_busy(mb), .pipe1_hazard(hz), .pipe1_isEBREAK(eb), .haltOnEbreak(hoe),
        .state(state), .progressPipe(progress), .stepPipe(step_pipe), .stallPipe(stall_pipe),
        .halted(halted), .instructionRetired(retired), .instretCount(cnt)
    );

    core_pipe_controller #(.RESET_RUN(1'b1), .INSTRET_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .management_run(1'b0), .management_halt(1'b0), .management_step(1'b0),
        .management_clearInstret(b_clr),
        .fetch_busy(b_fb), .memory_busy(1'b0), .pipe1_hazard(1'b0), .pipe1_isEBREAK(1'b0), .haltOnEbreak(1'b0),
        .state(b_state), .progressPipe(b_progress), .stepPipe(b_step_pipe), .stallPipe(b_stall_pipe),
        .halted(b_halted), .instructionRetired(b_retired), .instretCount(b_cnt)
    );

    localparam logic [8:0] R = 9'h100, H = 9'h080, S = 9'h040, C = 9'h020, FB = 9'h010,
                           MB = 9'h008, HZ = 9'h004, EB = 9'h002, HOE = 9'h001;
    // {state, progressPipe, stepPipe, stallPipe, instructionRetired, halted}
    localparam logic [5:0] E_HALT = 6'b000001, E_IDLE = 6'b110000, E_RET = 6'b111010, E_STALL = 6'b111100;

    typedef struct {
        logic [8:0]  in;
        logic [5:0]  exp;
        logic [31:0] cnt;
    } vec_t;

    typedef enum {M_HALT, M_RUN, M_STEP, M_DRAIN} mode_t;
    mode_t m;
    int unsigned mcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_in(input logic [8:0] v);
        {run, halt, step, clr, fb, mb, hz, eb, hoe} = v;
    endtask

    function automatic logic [5:0] outs();
        return {state, progress, step_pipe, stall_pipe, retired, halted};
    endfunction

    // Reference: compare this cycle's outputs, then advance the abstract mode and count
    task automatic model_cycle(input string tag);
        bit go, e_step, e_stall, e_ret;
        go      = (m == M_RUN) || (m == M_STEP);
        e_step  = go && !(fb || mb);
        e_stall = go && hz;
        e_ret   = e_step && !e_stall;
        chk({tag, "_outs"}, 32'(outs()), 32'({m != M_HALT, m != M_HALT, e_step, e_stall, e_ret, m == M_HALT}));
        chk({tag, "_cnt"}, cnt, mcnt);
        case (m)
            M_HALT:  m = step ? M_STEP : (run ? M_RUN : M_HALT);
            M_RUN:   if (halt || (e_ret && eb && hoe)) m = M_DRAIN;
            M_STEP:  if (halt || e_ret) m = M_DRAIN;
            M_DRAIN: if (!(fb || mb)) m = M_HALT;
        endcase
        mcnt = clr ? 0 : mcnt + (e_ret ? 1 : 0);
    endtask

    vec_t tbl[$];

    initial begin
        tbl = '{
            '{9'h0, E_HALT, 0}, '{S, E_HALT, 0}, '{9'h0, E_RET, 0}, '{9'h0, E_IDLE, 1}, '{9'h0, E_HALT, 1},
            '{R|H, E_HALT, 1}, '{MB, E_IDLE, 1}, '{MB|H, E_IDLE, 1}, '{MB, E_IDLE, 1}, '{9'h0, E_IDLE, 1},
            '{9'h0, E_HALT, 1}, '{R|C, E_HALT, 1},
            '{9'h0, E_RET, 0}, '{9'h0, E_RET, 1}, '{HZ, E_STALL, 2}, '{HZ, E_STALL, 2}, '{9'h0, E_RET, 2},
            '{9'h0, E_RET, 3}, '{9'h0, E_RET, 4}, '{9'h0, E_RET, 5}, '{9'h0, E_RET, 6}, '{9'h0, E_RET, 7},
            '{H, E_RET, 8}, '{9'h0, E_IDLE, 9}, '{9'h0, E_HALT, 9},
            '{R|HOE, E_HALT, 9}, '{EB|HOE, E_RET, 9}, '{HOE, E_IDLE, 10}, '{HOE, E_HALT, 10},
            '{R, E_HALT, 10}, '{EB, E_RET, 10}, '{R|S, E_RET, 11}, '{C, E_RET, 12}, '{H, E_RET, 0},
            '{9'h0, E_IDLE, 1}, '{9'h0, E_HALT, 1},
            '{S, E_HALT, 1}, '{HZ, E_STALL, 1}, '{FB, E_IDLE, 1}, '{9'h0, E_RET, 1}, '{9'h0, E_IDLE, 2},
            '{9'h0, E_HALT, 2}
        };

        repeat (2) @(negedge clk);
        #1;
        chk("reset_outs", 32'(outs()), 32'(E_HALT));
        chk("reset_cnt", cnt, 0);
        chk("reset_run_state", 32'(b_state), 1);
        chk("reset_run_busy_step", 32'(b_step_pipe), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            set_in(tbl[i].in);
            #1;
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].exp));
            chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].cnt);
        end

        @(negedge clk);
        set_in(9'h0);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        m = M_HALT;
        mcnt = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            set_in({$urandom_range(5) == 0, $urandom_range(9) == 0, $urandom_range(7) == 0,
                    $urandom_range(31) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                    $urandom_range(4) == 0, $urandom_range(5) == 0, $urandom_range(1) == 0});
            #1 model_cycle("rand");
        end

        @(negedge clk);
        set_in(S | FB);
        @(negedge clk);
        set_in(FB);
        #1 chk("step_held_state", 32'(state), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outs", 32'(outs()), 32'(E_HALT));
        chk("async_reset_cnt", cnt, 0);
        @(negedge clk);
        set_in(9'h0);
        rst_n = 1'b1;

        #1 chk("b_busy_step", 32'(b_step_pipe), 0);
        chk("b_busy_state", 32'(b_state), 1);
        b_fb = 1'b0;
        #1 chk("b_free_step", 32'(b_step_pipe), 1);
        repeat (15) @(negedge clk);
        #1 chk("b_cnt_max", 32'(b_cnt), 15);
        @(negedge clk);
        #1 chk("b_cnt_wrap", 32'(b_cnt), 0);
        repeat (2) @(negedge clk);
        b_clr = 1'b1;
        #1 chk("b_clr_retire", 32'(b_retired), 1);
        @(negedge clk);
        b_clr = 1'b0;
        #1 chk("b_clr_wins", 32'(b_cnt), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
